// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage byte-enable memory controller.
package mem_pkg;
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam int NUM_LANES = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;
endpackage

// File: rtl/mem_ctrl_be_datamem_be.sv
// Single-port synchronous data RAM with byte-lane write enables.
// READ_LATENCY=2 adds an output register behind the array read.
module datamem_be
  import mem_pkg::*;
#(
  parameter int WORD_ADDR_BITS = 8,
  parameter int READ_LATENCY   = 1
) (
  input  logic                      clk,
  input  logic                      re,
  input  logic [NUM_LANES-1:0]      we,
  input  logic [WORD_ADDR_BITS-1:0] addr,
  input  logic [31:0]               wdata,
  output logic [31:0]               rdata
);
  logic [31:0] mem [2**WORD_ADDR_BITS];
  logic [31:0] q1;

  always_ff @(posedge clk) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (we[l]) mem[addr][8*l +: 8] <= wdata[8*l +: 8];
    end
    if (re) q1 <= mem[addr];
  end

  generate
    if (READ_LATENCY == 2) begin : g_oreg
      logic [31:0] q2;
      always_ff @(posedge clk) q2 <= q1;
      assign rdata = q2;
    end else begin : g_noreg
      assign rdata = q1;
    end
  endgenerate
endmodule

// File: rtl/mem_ctrl_be.sv
// MEM-stage data-memory controller: sized loads/stores, lane enables,
// misalignment detection and a read-latency stall FSM.
//   state | meaning
//   IDLE  | accepting requests; a load here issues the RAM read and stalls
//   WAIT  | second cycle of a 2-cycle read, still stalling
//   RESP  | RAM data ready, read_valid=1, stall released
module mem_ctrl_be
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int WORD_ADDR_BITS = 8,
  parameter int READ_LATENCY   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic [31:0]           out_alu_result,
  output logic                  stall,
  output logic                  misaligned
);
  state_t                 state, state_nxt;
  logic                   mis_addr, is_idle, store_en, load_en;
  logic [NUM_LANES-1:0]   lane_we;
  logic [DATA_WIDTH-1:0]  wdata_rep, ram_rdata, ext, data_q;
  logic [1:0]             lat_off, lat_size;
  logic                   lat_uns;
  logic [7:0]             byte_v;
  logic [15:0]            half_v;

  assign out_alu_result = address;
  assign is_idle        = (state == ST_IDLE);

  always_comb begin
    mis_addr = 1'b0;
    case (mem_size)
      MEM_BYTE: mis_addr = 1'b0;
      MEM_HALF: mis_addr = address[0];
      default:  mis_addr = |address[1:0];
    endcase
  end

  // A simultaneous read+write is treated as a store; the read is dropped.
  assign misaligned = is_idle & (mem_read | mem_write) & mis_addr;
  assign store_en   = is_idle & mem_write & ~mis_addr;
  assign load_en    = is_idle & mem_read & ~mem_write & ~mis_addr;
  assign stall      = load_en | (state == ST_WAIT);
  assign read_valid = (state == ST_RESP);

  always_comb begin
    lane_we   = 4'b1111;
    wdata_rep = write_data;
    case (mem_size)
      MEM_BYTE: begin
        lane_we   = 4'b0001 << address[1:0];
        wdata_rep = {4{write_data[7:0]}};
      end
      MEM_HALF: begin
        lane_we   = address[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{write_data[15:0]}};
      end
      default: ;
    endcase
    if (!store_en) lane_we = '0;
  end

  datamem_be #(
    .WORD_ADDR_BITS(WORD_ADDR_BITS),
    .READ_LATENCY  (READ_LATENCY)
  ) u_ram (
    .clk  (clk),
    .re   (load_en),
    .we   (lane_we),
    .addr (address[WORD_ADDR_BITS+1:2]),
    .wdata(wdata_rep),
    .rdata(ram_rdata)
  );

  always_comb begin
    byte_v = ram_rdata[{lat_off, 3'b000} +: 8];
    half_v = lat_off[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (lat_size)
      MEM_BYTE: ext = {{24{~lat_uns & byte_v[7]}}, byte_v};
      MEM_HALF: ext = {{16{~lat_uns & half_v[15]}}, half_v};
      default:  ext = ram_rdata;
    endcase
  end

  // The response is shown combinationally in RESP and held afterwards.
  assign read_data = (state == ST_RESP) ? ext : data_q;

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: if (load_en) state_nxt = (READ_LATENCY == 2) ? ST_WAIT : ST_RESP;
      ST_WAIT: state_nxt = ST_RESP;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      data_q   <= '0;
      lat_off  <= 2'b00;
      lat_size <= MEM_WORD;
      lat_uns  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_en) begin
        lat_off  <= address[1:0];
        lat_size <= mem_size;
        lat_uns  <= mem_unsigned;
      end
      if (state == ST_RESP) data_q <= ext;
    end
  end
endmodule

// File: tb/tb_mem_ctrl_be.sv
// Directed bench: a READ_LATENCY=1 instance driven from a vector table and a
// READ_LATENCY=2 instance exercised by hand-written latency/reset sequences.
module tb_mem_ctrl_be;
  logic        clk = 1'b0;
  logic        rst   [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [1:0]  sz    [2];
  logic        uns   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdat  [2];
  logic [31:0] rdata [2];
  logic        rv    [2];
  logic [31:0] alu   [2];
  logic        stl   [2];
  logic        mis   [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_ctrl_be #(.DATA_WIDTH(32), .WORD_ADDR_BITS(8), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .reset(rst[0]), .mem_read(rd[0]), .mem_write(wr[0]), .mem_size(sz[0]),
    .mem_unsigned(uns[0]), .address(addr[0]), .write_data(wdat[0]), .read_data(rdata[0]),
    .read_valid(rv[0]), .out_alu_result(alu[0]), .stall(stl[0]), .misaligned(mis[0]));

  mem_ctrl_be #(.DATA_WIDTH(32), .WORD_ADDR_BITS(8), .READ_LATENCY(2)) u_l2 (
    .clk(clk), .reset(rst[1]), .mem_read(rd[1]), .mem_write(wr[1]), .mem_size(sz[1]),
    .mem_unsigned(uns[1]), .address(addr[1]), .write_data(wdat[1]), .read_data(rdata[1]),
    .read_valid(rv[1]), .out_alu_result(alu[1]), .stall(stl[1]), .misaligned(mis[1]));

  localparam int OP_ST = 0, OP_LD = 1, OP_MISLD = 2, OP_MISST = 3, OP_RDWR = 4;

  typedef struct {
    int          op;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] a;
    logic [31:0] d;
    string       nm;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs(input int i);
    rd[i] = 1'b0; wr[i] = 1'b0; sz[i] = 2'b10; uns[i] = 1'b0; addr[i] = '0; wdat[i] = '0;
  endtask

  task automatic do_store(input int i, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] d, input string nm);
    wr[i] = 1'b1; sz[i] = s; addr[i] = a; wdat[i] = d;
    @(negedge clk);
    chk({nm, " store stall"}, {31'd0, stl[i]}, 32'd0);
    chk({nm, " alu pass"}, alu[i], a);
    @(posedge clk); #1;
    wr[i] = 1'b0;
  endtask

  task automatic do_load(input int i, input logic [1:0] s, input logic u, input logic [31:0] a,
                         input logic [31:0] exp, input int exp_stall, input string nm);
    int  n;
    bit  got;
    n = 0; got = 0;
    rd[i] = 1'b1; sz[i] = s; uns[i] = u; addr[i] = a;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      if (rv[i]) got = 1;
      else begin
        if (stl[i]) n++;
        @(posedge clk); #1;
      end
    end
    rd[i] = 1'b0;
    chk({nm, " valid seen"}, {31'd0, got}, 32'd1);
    chk({nm, " stall cycles"}, n, exp_stall);
    chk({nm, " resp stall"}, {31'd0, stl[i]}, 32'd0);
    chk({nm, " data"}, rdata[i], exp);
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, " data held"}, rdata[i], exp);
    chk({nm, " valid drop"}, {31'd0, rv[i]}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_mis(input int i, input bit is_wr, input bit both, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] d, input bit exp_mis,
                        input string nm);
    rd[i] = ~is_wr | both; wr[i] = is_wr | both; sz[i] = s; addr[i] = a; wdat[i] = d;
    @(negedge clk);
    chk({nm, " misaligned"}, {31'd0, mis[i]}, {31'd0, exp_mis});
    chk({nm, " stall"}, {31'd0, stl[i]}, 32'd0);
    @(posedge clk); #1;
    rd[i] = 1'b0; wr[i] = 1'b0;
    @(negedge clk);
    chk({nm, " no valid"}, {31'd0, rv[i]}, 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t vecs[$];
  int   seen;

  initial begin
    vecs = '{
      '{OP_ST,    2'b10, 1'b0, 32'h10,  32'hDEADBEEF, "sw 10"},
      '{OP_LD,    2'b10, 1'b0, 32'h10,  32'hDEADBEEF, "lw 10 a"},
      '{OP_ST,    2'b00, 1'b0, 32'h13,  32'h00000080, "sb 13"},
      '{OP_LD,    2'b00, 1'b0, 32'h13,  32'hFFFFFF80, "lb 13"},
      '{OP_LD,    2'b00, 1'b1, 32'h13,  32'h00000080, "lbu 13"},
      '{OP_LD,    2'b10, 1'b0, 32'h10,  32'h80ADBEEF, "lw 10 b"},
      '{OP_ST,    2'b01, 1'b0, 32'h12,  32'h00001234, "sh 12"},
      '{OP_LD,    2'b01, 1'b0, 32'h12,  32'h00001234, "lh 12"},
      '{OP_LD,    2'b10, 1'b0, 32'h10,  32'h1234BEEF, "lw 10 c"},
      '{OP_LD,    2'b01, 1'b0, 32'h10,  32'hFFFFBEEF, "lh 10"},
      '{OP_LD,    2'b01, 1'b1, 32'h10,  32'h0000BEEF, "lhu 10"},
      '{OP_LD,    2'b00, 1'b1, 32'h11,  32'h000000BE, "lbu 11"},
      '{OP_LD,    2'b00, 1'b0, 32'h12,  32'h00000034, "lb 12"},
      '{OP_LD,    2'b11, 1'b0, 32'h10,  32'h1234BEEF, "size11 10"},
      '{OP_MISLD, 2'b10, 1'b0, 32'h11,  32'h0,        "lw 11"},
      '{OP_MISST, 2'b01, 1'b0, 32'h13,  32'h0000FFFF, "sh 13"},
      '{OP_LD,    2'b10, 1'b0, 32'h10,  32'h1234BEEF, "lw 10 d"},
      '{OP_RDWR,  2'b10, 1'b0, 32'h20,  32'h00000055, "rw 20"},
      '{OP_LD,    2'b10, 1'b0, 32'h20,  32'h00000055, "lw 20"},
      '{OP_ST,    2'b10, 1'b0, 32'h400, 32'hCAFEF00D, "sw 400"},
      '{OP_LD,    2'b10, 1'b0, 32'h0,   32'hCAFEF00D, "lw 0 alias"}
    };

    for (int i = 0; i < 2; i++) begin
      idle_inputs(i);
      rst[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset read_data %0d", i), rdata[i], 32'd0);
      chk($sformatf("reset read_valid %0d", i), {31'd0, rv[i]}, 32'd0);
      chk($sformatf("reset stall %0d", i), {31'd0, stl[i]}, 32'd0);
    end
    @(posedge clk); #1;

    foreach (vecs[k]) begin
      case (vecs[k].op)
        OP_ST:    do_store(0, vecs[k].size, vecs[k].a, vecs[k].d, vecs[k].nm);
        OP_LD:    do_load(0, vecs[k].size, vecs[k].uns, vecs[k].a, vecs[k].d, 1, vecs[k].nm);
        OP_MISLD: do_mis(0, 1'b0, 1'b0, vecs[k].size, vecs[k].a, vecs[k].d, 1'b1, vecs[k].nm);
        OP_MISST: do_mis(0, 1'b1, 1'b0, vecs[k].size, vecs[k].a, vecs[k].d, 1'b1, vecs[k].nm);
        default:  do_mis(0, 1'b1, 1'b1, vecs[k].size, vecs[k].a, vecs[k].d, 1'b0, vecs[k].nm);
      endcase
    end

    // Two-cycle read path, then reset while the read sits in WAIT.
    do_store(1, 2'b10, 32'h40, 32'h11223344, "l2 sw 40");
    do_load(1, 2'b10, 1'b0, 32'h40, 32'h11223344, 2, "l2 lw 40");
    do_load(1, 2'b00, 1'b0, 32'h43, 32'h00000011, 2, "l2 lb 43");

    rd[1] = 1'b1; sz[1] = 2'b10; uns[1] = 1'b0; addr[1] = 32'h40;
    @(posedge clk); #1;
    @(negedge clk);
    chk("l2 wait stall", {31'd0, stl[1]}, 32'd1);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0; rd[1] = 1'b0;
    @(negedge clk);
    chk("l2 post-reset stall", {31'd0, stl[1]}, 32'd0);
    chk("l2 post-reset valid", {31'd0, rv[1]}, 32'd0);
    chk("l2 post-reset data", rdata[1], 32'd0);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rv[1]) seen++;
    end
    chk("l2 no late response", seen, 0);
    @(posedge clk); #1;
    do_load(1, 2'b10, 1'b0, 32'h40, 32'h11223344, 2, "l2 lw 40 after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_ctrl_be.md
Name: mem_ctrl_be

Overview:
- Parametrised successor to the single-word data-memory controller in the MEM stage of the pipelined CPU.
- Adds byte/halfword/word loads and stores with sign/zero extension, byte-lane write enables and misalignment detection.
- Adds a read-latency FSM that stalls the pipeline while synchronous RAM data is in flight.
- out_alu_result pass-through is retained so the WB mux wiring is unchanged.

Parameters:
- DATA_WIDTH, 32, data bus width; fixed at 32 for this generation, since the lane logic assumes 4 byte lanes.
- WORD_ADDR_BITS, 8, log2 of RAM depth in words; word index = address[WORD_ADDR_BITS+1:2].
- READ_LATENCY, 1, RAM read latency in cycles; legal values 1 or 2 (2 adds an output register in the RAM).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- mem_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- mem_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
- address  in  32  byte address from ALU.
- write_data  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- read_data  out  32  extended load result.
- read_valid  out  1  read_data valid this cycle.
- out_alu_result  out  32  equals address (combinational pass-through).
- stall  out  1  freeze IF/ID/EX/MEM stage registers.
- misaligned  out  1  current request is misaligned; access suppressed.

Behaviour:
- Reset values: read_data 0, read_valid 0, stall 0, FSM in IDLE. RAM contents are not cleared.
- Alignment: half is misaligned if address[0]=1. Word is misaligned if address[1:0]!=0. Byte is never misaligned.
- misaligned is combinational and is asserted only in IDLE with a request present. A misaligned request performs no RAM access, no stall and no read_valid.
- Stores (IDLE, mem_write=1, aligned): single cycle, no stall.
  - Lane enables: byte = 1<<addr[1:0]; half = 0011 or 1100 by addr[1]; word = 1111.
  - write_data is replicated across lanes (byte to all 4, half to both halves).
  - The RAM is written at the posedge ending the cycle.
- mem_read and mem_write together: the store wins and the read is dropped (no stall).
- Loads, FSM states IDLE, WAIT, RESP:
  - Cycle T, IDLE, aligned mem_read: RAM read issued. addr[1:0], mem_size and mem_unsigned are latched. stall=1 combinationally.
  - READ_LATENCY=1: next state RESP.
  - READ_LATENCY=2: next state WAIT (stall=1 for one more cycle), then RESP.
  - RESP, one cycle: stall=0, read_valid=1. read_data = selected lane(s) extended per the latched size and sign; it holds this value until the next load response.
  - RESP always returns to IDLE. A new request is accepted no earlier than the cycle after RESP.
- The pipeline holds address and request inputs stable while stall=1. The controller uses only latched values after T.
- Load after store: a store at T followed by a load of the same word at T+1 returns the new data. Store and load are never in the same cycle.
- Address bits above WORD_ADDR_BITS+1 are ignored, so addresses alias modulo the RAM size.
- Reset in WAIT or RESP: next cycle is IDLE with stall 0 and read_valid 0. The in-flight read is discarded.
- Loads use a read-only RAM port, so contents are unaffected.

Decomposition:
- Shared package mem_pkg:
  - Size encodings MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10.
  - FSM state typedef (IDLE/WAIT/RESP).
  - Lane-enable width constant NUM_LANES=4.
- One sub-module, datamem_be: single-port synchronous RAM, 2^WORD_ADDR_BITS x 32.
  - 4-bit byte write enable; READ_LATENCY-parametrised output register.
- Lane select, extension and FSM live in mem_ctrl_be.

Test Plan:
- sw 0xDEADBEEF to 0x10, then lw 0x10 (READ_LATENCY=1) -> stall=1 for 1 cycle, then read_valid=1, read_data=0xDEADBEEF.
- sb 0x80 to 0x13, then lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lw 0x10 -> 0x80ADBEEF.
- sh 0x1234 to 0x12, then lh 0x12 -> 0x00001234; lw 0x10 -> 0x1234BEEF.
- lw 0x11 and sh 0x13 -> misaligned=1, stall=0, read_valid=0; a subsequent lw 0x10 is unchanged.
- READ_LATENCY=2: lw -> stall high exactly 2 cycles, read_valid on the 3rd. Reset asserted in WAIT -> next cycle stall=0 and read_valid=0 (no response ever issues); RAM data intact.
- mem_read and mem_write together at 0x20 with write_data 0x55 -> no stall; a later lw 0x20 returns 0x00000055.
- Address aliasing: sw to 0x400 -> lw 0x0 returns the same value (WORD_ADDR_BITS=8).
